// File: rtl/rd0_video_out_if.sv
// Prefetch-FIFO read handshake between the read-channel-0 FIFO and the video output stage.
// A pop occurs in any cycle where fifo_rd_en and fifo_rd_vld are both high.
interface rd0_video_out_if;
  logic        fifo_rd_vld;
  logic [15:0] fifo_rd_data;
  logic        fifo_rd_en;

  modport master (output fifo_rd_en, input fifo_rd_vld, input fifo_rd_data);
  modport slave  (input fifo_rd_en, output fifo_rd_vld, output fifo_rd_data);
endinterface

// File: rtl/rd0_video_out.sv
// Raster timing generator and RGB565->RGB888 pixel pump for read channel 0, running in the
// pixel clock domain; pops the prefetch FIFO once per active cycle and tracks underflow.
module rd0_video_out #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    ufl_clr,
  rd0_video_out_if.master         fifo,
  output logic                    frame_req,
  output logic                    vid_hs,
  output logic                    vid_vs,
  output logic                    vid_de,
  output logic [23:0]             vid_data,
  output logic                    ufl_flag,
  output logic [15:0]             ufl_cnt
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW       = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN
  } state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   h_cnt_q, h_cnt_d;
  logic [VW-1:0]   v_cnt_q, v_cnt_d;
  logic            vid_hs_q, vid_hs_d;
  logic            vid_vs_q, vid_vs_d;
  logic            vid_de_q, vid_de_d;
  logic [23:0]     vid_data_q, vid_data_d;
  logic            ufl_flag_q, ufl_flag_d;
  logic [15:0]     ufl_cnt_q, ufl_cnt_d;

  logic            de_i, hs_i, vs_i;
  logic            h_last, v_last, frame_end;

  function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  // Region decode compares in 32-bit space so a sync region ending exactly at the total still fits.
  assign de_i      = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
  assign hs_i      = (int'(h_cnt_q) >= HS_START) && (int'(h_cnt_q) < HS_END);
  assign vs_i      = (int'(v_cnt_q) >= VS_START) && (int'(v_cnt_q) < VS_END);
  assign h_last    = (int'(h_cnt_q) == H_TOTAL - 1);
  assign v_last    = (int'(v_cnt_q) == V_TOTAL - 1);
  assign frame_end = h_last && v_last;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d         = state_q;
    h_cnt_d         = h_cnt_q;
    v_cnt_d         = v_cnt_q;
    vid_hs_d        = ~HS_POL;
    vid_vs_d        = ~VS_POL;
    vid_de_d        = 1'b0;
    vid_data_d      = '0;
    ufl_flag_d      = ufl_flag_q;
    ufl_cnt_d       = ufl_cnt_q;
    fifo.fifo_rd_en = 1'b0;
    frame_req       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (en) state_d = S_ARM;
      end

      S_ARM, S_RUN: begin
        if (h_last) begin
          h_cnt_d = '0;
          v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
        end else begin
          h_cnt_d = h_cnt_q + HW'(1);
        end

        vid_hs_d  = ~(hs_i ^ HS_POL);
        vid_vs_d  = ~(vs_i ^ VS_POL);
        frame_req = (h_cnt_q == '0) && (int'(v_cnt_q) == V_ACTIVE);

        // en is only honoured at the frame boundary so a frame is never cut short.
        if (frame_end) state_d = en ? S_RUN : S_IDLE;

        if (state_q == S_RUN) begin
          fifo.fifo_rd_en = de_i;
          vid_de_d        = de_i;
          if (de_i && fifo.fifo_rd_vld) vid_data_d = rgb565_to_888(fifo.fifo_rd_data);
          // A missing pixel is shown black and skipped; timing never stalls.
          if (de_i && !fifo.fifo_rd_vld) begin
            ufl_flag_d = 1'b1;
            if (ufl_cnt_q != 16'hFFFF) ufl_cnt_d = ufl_cnt_q + 16'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (ufl_clr) begin
      ufl_flag_d = 1'b0;
      ufl_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      vid_hs_q   <= ~HS_POL;
      vid_vs_q   <= ~VS_POL;
      vid_de_q   <= 1'b0;
      vid_data_q <= '0;
      ufl_flag_q <= 1'b0;
      ufl_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      vid_hs_q   <= vid_hs_d;
      vid_vs_q   <= vid_vs_d;
      vid_de_q   <= vid_de_d;
      vid_data_q <= vid_data_d;
      ufl_flag_q <= ufl_flag_d;
      ufl_cnt_q  <= ufl_cnt_d;
    end
  end

  assign vid_hs   = vid_hs_q;
  assign vid_vs   = vid_vs_q;
  assign vid_de   = vid_de_q;
  assign vid_data = vid_data_q;
  assign ufl_flag = ufl_flag_q;
  assign ufl_cnt  = ufl_cnt_q;

endmodule

// File: tb/tb_rd0_video_out.sv
// Bench for rd0_video_out with an 8x6 raster; expected outputs come from frame position
// arithmetic and a pixel queue standing in for the prefetch FIFO.
module tb_rd0_video_out;

  localparam int HA = 4, HF = 1, HSW = 2, HB = 1;
  localparam int VA = 3, VF = 1, VSW = 1, VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FRAME = HT * VT;

  typedef enum {M_IDLE, M_ARM, M_RUN} mode_e;

  logic        clk = 1'b0;
  logic        rst, en, ufl_clr;
  logic        frame_req, vid_hs, vid_vs, vid_de, ufl_flag;
  logic [23:0] vid_data;
  logic [15:0] ufl_cnt;

  rd0_video_out_if rd_if ();

  rd0_video_out #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .ufl_clr(ufl_clr), .fifo(rd_if),
    .frame_req(frame_req), .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de),
    .vid_data(vid_data), .ufl_flag(ufl_flag), .ufl_cnt(ufl_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  logic [15:0] pix_q[$];
  logic        exp_hs, exp_vs, exp_de, exp_flag;
  logic [23:0] exp_data;
  logic [15:0] exp_cnt;
  int pops, req_seen, hs_seen, vs_seen, de_seen;
  bit kill[FRAME];
  bit clr_at[FRAME];
  bit rnd_vld = 1'b0;
  int en_off_at = -1;

  function automatic logic [23:0] expand(input logic [15:0] p);
    logic [7:0] r, g, b;
    r = {3'b0, p[15:11]};
    g = {2'b0, p[10:5]};
    b = {3'b0, p[4:0]};
    return {8'((r << 3) | (r >> 2)), 8'((g << 2) | (g >> 4)), 8'((b << 3) | (b >> 2))};
  endfunction

  task automatic set_reset_expect();
    exp_hs = 0; exp_vs = 0; exp_de = 0; exp_data = '0; exp_flag = 0; exp_cnt = '0;
  endtask

  task automatic clear_counts();
    pops = 0; req_seen = 0; hs_seen = 0; vs_seen = 0; de_seen = 0;
  endtask

  // One pixel clock at raster position pos of a frame of kind m.
  task automatic tick(input mode_e m, input int pos, input bit vld, input bit clr);
    int line, col;
    bit act, pop;
    logic [15:0] head;
    line = pos / HT;
    col  = pos % HT;
    if (pix_q.size() == 0) pix_q.push_back(16'($urandom));
    head = pix_q[0];
    rd_if.fifo_rd_vld  = vld;
    rd_if.fifo_rd_data = head;
    ufl_clr            = clr;
    @(negedge clk);
    act = (m == M_RUN) && (col < HA) && (line < VA);
    n_cmp++; if (rd_if.fifo_rd_en !== act) begin n_err++; $display("FAIL fifo_rd_en pos=%0d got=%b exp=%b", pos, rd_if.fifo_rd_en, act); end
    n_cmp++; if (frame_req !== ((m != M_IDLE) && pos == VA * HT)) begin n_err++; $display("FAIL frame_req pos=%0d got=%b", pos, frame_req); end
    n_cmp++; if (vid_hs !== exp_hs) begin n_err++; $display("FAIL vid_hs pos=%0d got=%b exp=%b", pos, vid_hs, exp_hs); end
    n_cmp++; if (vid_vs !== exp_vs) begin n_err++; $display("FAIL vid_vs pos=%0d got=%b exp=%b", pos, vid_vs, exp_vs); end
    n_cmp++; if (vid_de !== exp_de) begin n_err++; $display("FAIL vid_de pos=%0d got=%b exp=%b", pos, vid_de, exp_de); end
    n_cmp++; if (vid_data !== exp_data) begin n_err++; $display("FAIL vid_data pos=%0d got=%h exp=%h", pos, vid_data, exp_data); end
    n_cmp++; if (ufl_flag !== exp_flag) begin n_err++; $display("FAIL ufl_flag pos=%0d got=%b exp=%b", pos, ufl_flag, exp_flag); end
    n_cmp++; if (ufl_cnt !== exp_cnt) begin n_err++; $display("FAIL ufl_cnt pos=%0d got=%0d exp=%0d", pos, ufl_cnt, exp_cnt); end
    req_seen += int'(frame_req);
    hs_seen  += int'(vid_hs);
    vs_seen  += int'(vid_vs);
    de_seen  += int'(vid_de);
    pop      = act && vld;
    exp_hs   = (m != M_IDLE) && (col >= HA + HF) && (col < HA + HF + HSW);
    exp_vs   = (m != M_IDLE) && (line >= VA + VF) && (line < VA + VF + VSW);
    exp_de   = act;
    exp_data = pop ? expand(head) : 24'h0;
    if (clr) begin
      exp_flag = 0; exp_cnt = '0;
    end else if (act && !vld) begin
      exp_flag = 1;
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end
    if (pop) pops++;
    @(posedge clk); #1;
    if (pop) void'(pix_q.pop_front());
  endtask

  task automatic run_frame(input mode_e m);
    bit vld, clr;
    for (int p = 0; p < FRAME; p++) begin
      if (p == en_off_at) en = 1'b0;
      vld = rnd_vld ? ($urandom_range(3) != 0) : !kill[p];
      clr = clr_at[p] || (rnd_vld && $urandom_range(15) == 0);
      tick(m, p, vld, clr);
    end
    kill = '{default: 1'b0};
    clr_at = '{default: 1'b0};
    en_off_at = -1;
    rnd_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1; en = 0; ufl_clr = 0;
    rd_if.fifo_rd_vld = 1; rd_if.fifo_rd_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    set_reset_expect();
    for (int i = 0; i < 20; i++) tick(M_IDLE, 0, 1'b1, 1'b0);
  endtask

  task automatic test_enable_arm();
    en = 1;
    tick(M_IDLE, 0, 1'b1, 1'b0);
    clear_counts();
    run_frame(M_ARM);
    n_cmp++; if (req_seen != 1) begin n_err++; $display("FAIL arm_frame_req_count got=%0d exp=1", req_seen); end
    n_cmp++; if (hs_seen != 2 * VT) begin n_err++; $display("FAIL arm_hs_count got=%0d exp=%0d", hs_seen, 2 * VT); end
    n_cmp++; if (vs_seen != HT) begin n_err++; $display("FAIL arm_vs_count got=%0d exp=%0d", vs_seen, HT); end
    n_cmp++; if (de_seen != 0) begin n_err++; $display("FAIL arm_de_count got=%0d exp=0", de_seen); end
  endtask

  task automatic test_pixel_path();
    pix_q.delete();
    pix_q.push_back(16'hF800); pix_q.push_back(16'h07E0);
    pix_q.push_back(16'h001F); pix_q.push_back(16'hFFFF);
    for (int i = 0; i < 12; i++) pix_q.push_back(16'($urandom));
    clear_counts();
    run_frame(M_RUN);
    n_cmp++; if (pops != HA * VA) begin n_err++; $display("FAIL pixel_pops got=%0d exp=%0d", pops, HA * VA); end
    n_cmp++; if (de_seen != HA * VA) begin n_err++; $display("FAIL pixel_de_count got=%0d exp=%0d", de_seen, HA * VA); end
    n_cmp++; if (req_seen != 1) begin n_err++; $display("FAIL run_frame_req_count got=%0d exp=1", req_seen); end
  endtask

  task automatic test_underflow();
    kill[HT] = 1; kill[HT + 1] = 1;
    clear_counts();
    run_frame(M_RUN);
    n_cmp++; if (ufl_flag !== 1'b1) begin n_err++; $display("FAIL ufl_flag_after got=%b exp=1", ufl_flag); end
    n_cmp++; if (ufl_cnt !== 16'd2) begin n_err++; $display("FAIL ufl_cnt_after got=%0d exp=2", ufl_cnt); end
    n_cmp++; if (pops != HA * VA - 2) begin n_err++; $display("FAIL ufl_pops got=%0d exp=%0d", pops, HA * VA - 2); end
  endtask

  task automatic test_clear_priority();
    kill[2 * HT] = 1; clr_at[2 * HT] = 1;
    run_frame(M_RUN);
    n_cmp++; if (ufl_cnt !== 16'd0) begin n_err++; $display("FAIL clr_cnt_after got=%0d exp=0", ufl_cnt); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      rnd_vld = 1;
      run_frame(M_RUN);
    end
  endtask

  task automatic test_disable_mid_frame();
    en_off_at = 2 * HT + 4;
    clear_counts();
    run_frame(M_RUN);
    n_cmp++; if (pops != HA * VA) begin n_err++; $display("FAIL disable_pops got=%0d exp=%0d", pops, HA * VA); end
    for (int i = 0; i < 10; i++) tick(M_IDLE, 0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_line();
    en = 1;
    tick(M_IDLE, 0, 1'b1, 1'b0);
    run_frame(M_ARM);
    for (int p = 0; p < HT + 3; p++) tick(M_RUN, p, p != HT + 1, 1'b0);
    rst = 1;
    rd_if.fifo_rd_vld = 1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({vid_hs, vid_vs, vid_de} !== 3'b000) begin n_err++; $display("FAIL rst_sync_de got=%b exp=000", {vid_hs, vid_vs, vid_de}); end
    n_cmp++; if (vid_data !== 24'h0) begin n_err++; $display("FAIL rst_vid_data got=%h exp=000000", vid_data); end
    n_cmp++; if ({rd_if.fifo_rd_en, frame_req} !== 2'b00) begin n_err++; $display("FAIL rst_rd_en_req got=%b exp=00", {rd_if.fifo_rd_en, frame_req}); end
    n_cmp++; if ({ufl_flag, ufl_cnt} !== 17'h0) begin n_err++; $display("FAIL rst_ufl got=%b/%0d exp=0/0", ufl_flag, ufl_cnt); end
    rst = 0; en = 0;
    @(posedge clk); #1;
    pix_q.delete();
    set_reset_expect();
    for (int i = 0; i < 5; i++) tick(M_IDLE, 0, 1'b1, 1'b0);
  endtask

  initial begin
    kill = '{default: 1'b0};
    clr_at = '{default: 1'b0};
    test_reset();
    test_enable_arm();
    test_pixel_path();
    test_underflow();
    test_clear_priority();
    test_random();
    test_disable_mid_frame();
    test_reset_mid_line();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
